// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared widths, opcodes and FSM encoding for the memory access unit
package mem_access_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 6;
  localparam int SEL_W      = DATA_W / 8;

  localparam logic [OP_W-1:0] OP_LB  = 6'h20;
  localparam logic [OP_W-1:0] OP_LH  = 6'h21;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mau_state_e;

  // Byte ops never fault; unknown opcodes are treated as byte-safe.
  function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      OP_LW, OP_SW:         return |addr_lo;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// rtl/mem_access_unit_load_aligner.sv - picks and extends the addressed byte/halfword of a load word
module load_aligner
  import mem_access_unit_pkg::*;
(
  input  logic [OP_W-1:0]   inst_op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (inst_op)
      OP_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  value = {24'h000000, byte_sel};
      OP_LH:   value = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  value = {16'h0000, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: drives a req/ack data bus, stalls the front end, aligns loads
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_en_in,
  input  logic                  ram_write_en_in,
  input  logic [OP_W-1:0]       inst_op_in,
  input  logic [DATA_W-1:0]     result_in,
  input  logic [DATA_W-1:0]     reg_data_2_in,
  input  logic                  write_reg_en_in,
  input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
  input  logic                  write_hilo_en_in,
  input  logic [DATA_W-1:0]     write_hi_data_in,
  input  logic [DATA_W-1:0]     write_lo_data_in,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [SEL_W-1:0]      ram_sel,
  output logic [DATA_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic                  ram_ack,
  output logic                  mem_stall_request,
  output logic                  write_reg_en_out,
  output logic [REG_ADDR_W-1:0] write_reg_addr_out,
  output logic [DATA_W-1:0]     write_reg_data_out,
  output logic                  write_hilo_en_out,
  output logic [DATA_W-1:0]     write_hi_data_out,
  output logic [DATA_W-1:0]     write_lo_data_out,
  output logic                  addr_error,
  output logic                  bus_error
);

  mau_state_e        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              ram_we_q, ram_we_d;
  logic [SEL_W-1:0]  ram_sel_q, ram_sel_d;
  logic [DATA_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic              misaligned, mem_go, timeout;
  logic [SEL_W-1:0]  sel_new;
  logic [DATA_W-1:0] wdata_new, load_value;
  logic              wb_en;
  logic [DATA_W-1:0] wb_data;

  load_aligner u_load_aligner (
    .inst_op (inst_op_in),
    .addr_lo (result_in[1:0]),
    .rdata   (rdata_q),
    .value   (load_value)
  );

  assign misaligned = ram_en_in && is_misaligned(inst_op_in, result_in[1:0]);
  assign mem_go     = ram_en_in && !misaligned;
  assign timeout    = (wait_cnt_q == 8'(ACK_TIMEOUT - 1));

  // Stores replicate the datum across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    sel_new   = 4'b1111;
    wdata_new = reg_data_2_in;
    if (ram_write_en_in) begin
      case (inst_op_in)
        OP_SB: begin
          sel_new   = 4'b0001 << result_in[1:0];
          wdata_new = {4{reg_data_2_in[7:0]}};
        end
        OP_SH: begin
          sel_new   = 4'b0011 << result_in[1:0];
          wdata_new = {2{reg_data_2_in[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d           = state_q;
    wait_cnt_d        = wait_cnt_q;
    rdata_d           = rdata_q;
    bus_err_d         = 1'b0;
    ram_we_d          = ram_we_q;
    ram_sel_d         = ram_sel_q;
    ram_addr_d        = ram_addr_q;
    ram_wdata_d       = ram_wdata_q;
    ram_req           = 1'b0;
    mem_stall_request = 1'b0;
    addr_error        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_stall_request = mem_go;
        addr_error        = misaligned;
        if (mem_go) begin
          state_d     = ST_BUSY;
          wait_cnt_d  = 8'd0;
          ram_we_d    = ram_write_en_in;
          ram_sel_d   = sel_new;
          ram_addr_d  = {result_in[DATA_W-1:2], 2'b00};
          ram_wdata_d = wdata_new;
        end
      end
      ST_BUSY: begin
        ram_req           = 1'b1;
        mem_stall_request = 1'b1;
        // An ack landing on the last allowed cycle still counts as a completion.
        if (ram_ack) begin
          rdata_d = ram_rdata;
          state_d = ST_DONE;
        end else if (timeout) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (!rst) begin
      mem_stall_request = 1'b0;
      addr_error        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 8'd0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_sel_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      ram_we_q    <= ram_we_d;
      ram_sel_q   <= ram_sel_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // While stalled the stage presents a bubble so WB never commits a half-finished load.
  always_comb begin
    wb_en   = write_reg_en_in;
    wb_data = result_in;
    if (ram_en_in) begin
      if (ram_write_en_in || misaligned || mem_stall_request || (state_q == ST_DONE && bus_err_q))
        wb_en = 1'b0;
      if (!ram_write_en_in && state_q == ST_DONE)
        wb_data = load_value;
    end
  end

  assign ram_we             = ram_we_q;
  assign ram_sel            = ram_sel_q;
  assign ram_addr           = ram_addr_q;
  assign ram_wdata          = ram_wdata_q;
  assign bus_error          = bus_err_q;
  assign write_reg_en_out   = rst && wb_en;
  assign write_reg_addr_out = rst ? write_reg_addr_in : '0;
  assign write_reg_data_out = rst ? wb_data : '0;
  assign write_hilo_en_out  = rst && write_hilo_en_in;
  assign write_hi_data_out  = rst ? write_hi_data_in : '0;
  assign write_lo_data_out  = rst ? write_lo_data_in : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en_in, ram_write_en_in;
  logic [5:0]  inst_op_in;
  logic [31:0] result_in, reg_data_2_in;
  logic        write_reg_en_in;
  logic [4:0]  write_reg_addr_in;
  logic        write_hilo_en_in;
  logic [31:0] write_hi_data_in, write_lo_data_in;
  logic        ram_req, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ack;
  logic        mem_stall_request;
  logic        write_reg_en_out;
  logic [4:0]  write_reg_addr_out;
  logic [31:0] write_reg_data_out;
  logic        write_hilo_en_out;
  logic [31:0] write_hi_data_out, write_lo_data_out;
  logic        addr_error, bus_error;

  always #5 clk = ~clk;

  mem_access_unit #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ram_en_in(ram_en_in), .ram_write_en_in(ram_write_en_in), .inst_op_in(inst_op_in),
    .result_in(result_in), .reg_data_2_in(reg_data_2_in),
    .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
    .write_hilo_en_in(write_hilo_en_in), .write_hi_data_in(write_hi_data_in),
    .write_lo_data_in(write_lo_data_in),
    .ram_req(ram_req), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .mem_stall_request(mem_stall_request),
    .write_reg_en_out(write_reg_en_out), .write_reg_addr_out(write_reg_addr_out),
    .write_reg_data_out(write_reg_data_out), .write_hilo_en_out(write_hilo_en_out),
    .write_hi_data_out(write_hi_data_out), .write_lo_data_out(write_lo_data_out),
    .addr_error(addr_error), .bus_error(bus_error)
  );

  typedef struct {
    logic en, we; logic [5:0] op; logic [31:0] addr, data, rdata; int delay;
    logic wr_en; logic [4:0] wr_addr; logic hilo_en; logic [31:0] hi, lo;
  } op_t;
  typedef struct {
    logic wr_en; logic [4:0] wr_addr; logic [31:0] wr_data; bit chk_data;
    logic hilo_en; logic [31:0] hi, lo; logic aerr, berr; int stalls;
  } resp_t;
  typedef struct { logic [31:0] addr, wdata, rdata; logic [3:0] sel; logic we; int delay; } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      default:             return 4;
    endcase
  endfunction

  // Reference behaviour: little-endian byte arithmetic on the word, no lane tables.
  function automatic void model(input op_t o, output resp_t r, output bus_t b, output bit has_bus);
    int sz, lo, busy;
    bit tmo;
    logic [31:0] v;
    sz = size_of(o.op);
    lo = int'(o.addr % 4);
    r.wr_addr = o.wr_addr; r.hilo_en = o.hilo_en; r.hi = o.hi; r.lo = o.lo;
    r.wr_en = o.wr_en; r.wr_data = o.addr; r.chk_data = 1'b1;
    r.aerr = 1'b0; r.berr = 1'b0; r.stalls = 0;
    b.addr = 0; b.wdata = 0; b.rdata = 0; b.sel = 0; b.we = 0; b.delay = 0;
    has_bus = 1'b0;
    if (o.en) begin
      if ((o.addr % sz) != 0) begin
        r.aerr = 1'b1; r.wr_en = 1'b0; r.chk_data = 1'b0;
      end else begin
        has_bus = 1'b1;
        tmo = (o.delay + 1 > TMO);
        busy = tmo ? TMO : o.delay + 1;
        r.stalls = 1 + busy;
        r.berr = tmo;
        b.addr = o.addr - o.addr % 4; b.we = o.we; b.delay = o.delay; b.rdata = o.rdata;
        b.sel = o.we ? 4'(((1 << sz) - 1) << lo) : 4'hF;
        for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = o.data[8*(i % sz) +: 8];
        if (o.we) begin
          r.wr_en = 1'b0; r.chk_data = 1'b0;
        end else if (tmo) begin
          r.wr_en = 1'b0; r.wr_data = 0;
        end else begin
          v = o.rdata >> (8 * lo);
          if (sz < 4) begin
            v = v & ((32'd1 << (8 * sz)) - 1);
            if ((o.op == 6'h20 || o.op == 6'h21) && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
          end
          r.wr_data = v;
        end
      end
    end
  endfunction

  function automatic op_t mk(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] rdata, input int delay);
    op_t o;
    o.en = 1'b1; o.op = op; o.we = (op == 6'h28 || op == 6'h29 || op == 6'h2B);
    o.addr = addr; o.data = data; o.rdata = rdata; o.delay = delay;
    o.wr_en = 1'b1; o.wr_addr = 5'd9; o.hilo_en = 1'b1; o.hi = 32'h1111_2222; o.lo = 32'h3333_4444;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    logic [5:0] ops [8];
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    o.en = ($urandom_range(0, 3) != 0);
    o.op = o.en ? ops[$urandom_range(0, 7)] : 6'($urandom);
    o.we = o.en && (o.op inside {6'h28, 6'h29, 6'h2B});
    o.addr = $urandom;
    if ($urandom_range(0, 1) == 1) o.addr[1:0] = 2'b00;
    o.data = $urandom; o.rdata = $urandom;
    o.delay = ($urandom_range(0, 4) == 0) ? $urandom_range(TMO, TMO + 3) : $urandom_range(0, TMO - 1);
    o.wr_en = 1'($urandom_range(0, 1)); o.wr_addr = 5'($urandom);
    o.hilo_en = 1'($urandom_range(0, 1)); o.hi = $urandom; o.lo = $urandom;
    return o;
  endfunction

  task automatic apply(input op_t o);
    ram_en_in = o.en; ram_write_en_in = o.we; inst_op_in = o.op;
    result_in = o.addr; reg_data_2_in = o.data;
    write_reg_en_in = o.wr_en; write_reg_addr_in = o.wr_addr;
    write_hilo_en_in = o.hilo_en; write_hi_data_in = o.hi; write_lo_data_in = o.lo;
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Called just after a rising edge; returns just after the edge that retires the op.
  task automatic run_op(input op_t o);
    resp_t r; bus_t b; bit hb; int n;
    model(o, r, b, hb);
    resp_q.push_back(r);
    if (hb) bus_q.push_back(b);
    apply(o);
    n = 0;
    do begin @(negedge clk); n++; end while (mem_stall_request && n < 200);
    if (mem_stall_request) begin
      checks++; errors++;
      $display("FAIL retire_bound stall still high after %0d cycles, required release", n);
      finish_run();
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    int stalls;
    resp_t e;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst) stalls = 0;
      else if (mem_stall_request) begin
        stalls++;
        check("bus_error_while_stalled", bus_error, 0);
      end else if (resp_q.size() > 0) begin
        e = resp_q.pop_front();
        check("stall_cycles", stalls, e.stalls);
        check("write_reg_en", write_reg_en_out, e.wr_en);
        check("write_reg_addr", write_reg_addr_out, e.wr_addr);
        if (e.chk_data) check("write_reg_data", write_reg_data_out, e.wr_data);
        check("hilo_en", write_hilo_en_out, e.hilo_en);
        check("hi_data", write_hi_data_out, e.hi);
        check("lo_data", write_lo_data_out, e.lo);
        check("addr_error", addr_error, e.aerr);
        check("bus_error", bus_error, e.berr);
        stalls = 0;
      end
    end
  end

  initial begin : responder
    int cnt;
    bus_t cur;
    cnt = 0; cur.delay = 0; cur.rdata = 0;
    ram_ack = 1'b0; ram_rdata = '0;
    forever begin
      @(negedge clk);
      if (ram_req) begin
        if (cnt == 0) begin
          if (bus_q.size() == 0) begin
            check("request_without_op", ram_req, 0);
            cur.delay = 0; cur.rdata = 0;
          end else begin
            cur = bus_q.pop_front();
            check("ram_addr", ram_addr, cur.addr);
            check("ram_sel", ram_sel, cur.sel);
            check("ram_we", ram_we, cur.we);
            if (cur.we) check("ram_wdata", ram_wdata, cur.wdata);
          end
        end
        ram_ack = (cnt == cur.delay);
        ram_rdata = ram_ack ? cur.rdata : $urandom;
        cnt++;
      end else begin
        cnt = 0;
        ram_ack = ($urandom_range(0, 3) == 0);
        ram_rdata = $urandom;
      end
    end
  end

  initial begin : stimulus
    op_t o;
    bus_t b;
    int n;
    rst = 1'b0;
    apply(mk(6'h23, 32'h100, 32'hCAFE_F00D, 0, 0));
    #12;
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_sel", ram_sel, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_stall", mem_stall_request, 0);
    check("rst_wr_en", write_reg_en_out, 0);
    check("rst_wr_data", write_reg_data_out, 0);
    check("rst_hilo_en", write_hilo_en_out, 0);
    check("rst_errors", {addr_error, bus_error}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op(mk(6'h23, 32'h100, 0, 32'hDEAD_BEEF, 0));
    run_op(mk(6'h20, 32'h103, 0, 32'h80FF_FFFF, 0));
    run_op(mk(6'h24, 32'h103, 0, 32'h80FF_FFFF, 1));
    run_op(mk(6'h29, 32'h102, 32'h1234_ABCD, 0, 0));
    run_op(mk(6'h23, 32'h101, 0, 0, 0));
    run_op(mk(6'h23, 32'h200, 0, 32'h5555_AAAA, 1000));
    run_op(mk(6'h21, 32'h302, 0, 32'h8001_7FFF, TMO - 1));
    run_op(mk(6'h25, 32'h302, 0, 32'h8001_7FFF, TMO));
    for (int i = 0; i < 400; i++) run_op(rand_op());

    mon_en = 1'b0;
    ram_en_in = 1'b0;
    @(posedge clk); #1;
    check("resp_queue_drained", resp_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);

    o = mk(6'h23, 32'h400, 0, 0, 1000);
    b.addr = 32'h400; b.we = 1'b0; b.sel = 4'hF; b.wdata = 0; b.rdata = 0; b.delay = 1000;
    bus_q.push_back(b);
    apply(o);
    n = 0;
    while (!ram_req && n < 20) begin @(negedge clk); n++; end
    check("busy_reached", ram_req, 1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_busy_ram_req", ram_req, 0);
    check("rst_busy_stall", mem_stall_request, 0);
    check("rst_busy_sel", ram_sel, 0);
    check("rst_busy_addr", ram_addr, 0);
    check("rst_busy_wr_en", write_reg_en_out, 0);
    ram_en_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("req_after_reset", ram_req, 0);
      check("stall_after_reset", mem_stall_request, 0);
    end
    check("bus_queue_after_reset", bus_q.size(), 0);
    finish_run();
  end

endmodule
